// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM status codes and the memory arbiter state.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } arb_state_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Per-grant watchdog: counts grant cycles without ACCESS and flags the cycle that
// uses up the TIMEOUT budget.
module arb_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [3:0] count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

    // Fires combinationally on the TIMEOUT-th waiting cycle so the grant ends there.
    assign expired = enable && (count == 4'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data access, data first.
// Optional instruction-fetch fairness counter is compiled in with `MEM_ARB_FAIR_EN.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT    = 15,
    parameter int FAIR_LIMIT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       iREN,
    input  word_t      iaddr,
    output logic       iwait,
    output word_t      iload,
    input  logic       dREN,
    input  logic       dWEN,
    input  word_t      daddr,
    input  word_t      dstore,
    output logic       dwait,
    output word_t      dload,
    output logic       ramREN,
    output logic       ramWEN,
    output word_t      ramaddr,
    output word_t      ramstore,
    input  word_t      ramload,
    input  ramstate_t  ramstate,
    output logic       err,
    output arb_state_t arb_state
);

    // Handshake: a requester holds its request and address stable; the access is
    // done in the single cycle its wait line is low, when load data is valid.

    arb_state_t state, next_state;
    logic d_req, access, tmo_en, expired, set_err, fair_force;

    assign d_req     = dREN | dWEN;
    assign access    = (ramstate == ACCESS);
    assign tmo_en    = (state != IDLE) && !access;
    assign arb_state = state;

    arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (state == IDLE),
        .enable  (tmo_en),
        .expired (expired)
    );

`ifdef MEM_ARB_FAIR_EN
    localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);
    logic [FAIR_W-1:0] fair_cnt;

    assign fair_force = iREN && (fair_cnt == FAIR_W'(FAIR_LIMIT));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fair_cnt <= '0;
        end else if (state == IDLE && next_state == GRANT_I) begin
            fair_cnt <= '0;
        end else if (state == IDLE && next_state == GRANT_D && iREN) begin
            fair_cnt <= fair_cnt + FAIR_W'(1);
        end
    end
`else
    localparam int unused_fair_limit = FAIR_LIMIT;
    assign fair_force = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        set_err    = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        iload      = '0;
        dwait      = 1'b1;
        dload      = '0;
        case (state)
            IDLE: begin
                if (fair_force) begin
                    next_state = GRANT_I;
                end else if (d_req) begin
                    next_state = GRANT_D;
                end else if (iREN) begin
                    next_state = GRANT_I;
                end
            end
            GRANT_D: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                // A withdrawn request ends the grant quietly, whatever the RAM reports.
                if (!d_req) begin
                    next_state = IDLE;
                end else if (access) begin
                    dwait      = 1'b0;
                    dload      = ramload;
                    next_state = IDLE;
                end else if (ramstate == ERROR || expired) begin
                    set_err    = 1'b1;
                    next_state = IDLE;
                end
            end
            GRANT_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (access) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    next_state = IDLE;
                end else if (ramstate == ERROR || expired) begin
                    set_err    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed vector table, multi-cycle corner sequences and
// a randomized run against a transaction-level reference model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int TIMEOUT    = 15;
    localparam int FAIR_LIMIT = 4;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR_ON = 1'b1;
`else
    localparam bit FAIR_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       iREN, dREN, dWEN;
    word_t      iaddr, daddr, dstore, ramload;
    logic       iwait, dwait, ramREN, ramWEN, err;
    word_t      iload, dload, ramaddr, ramstore;
    ramstate_t  ramstate;
    arb_state_t arb_state;

    int total = 0;
    int bad   = 0;

    memory_arbiter #(.TIMEOUT(TIMEOUT), .FAIR_LIMIT(FAIR_LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err), .arb_state(arb_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int m_owner;   // 0 = nobody, 1 = instruction side, 2 = data side
    int m_waited;  // grant cycles spent without ACCESS
    int m_fair;    // data grants taken while a fetch waited
    bit m_err;

    logic       e_ren, e_wen, e_iwait, e_dwait, e_err;
    word_t      e_addr, e_store, e_iload, e_dload;
    arb_state_t e_st;

    task automatic model_reset();
        m_owner  = 0;
        m_waited = 0;
        m_fair   = 0;
        m_err    = 1'b0;
    endtask

    task automatic model_expect();
        bit dreq;
        bit acc;
        dreq    = dREN | dWEN;
        acc     = (ramstate == ACCESS);
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_addr  = '0;
        e_store = '0;
        e_iwait = 1'b1;
        e_iload = '0;
        e_dwait = 1'b1;
        e_dload = '0;
        e_err   = m_err;
        e_st    = (m_owner == 1) ? GRANT_I : (m_owner == 2) ? GRANT_D : IDLE;
        if (m_owner == 2) begin
            e_ren   = dREN;
            e_wen   = dWEN;
            e_addr  = daddr;
            e_store = dstore;
            if (dreq && acc) begin
                e_dwait = 1'b0;
                e_dload = ramload;
            end
        end else if (m_owner == 1) begin
            e_ren  = iREN;
            e_addr = iaddr;
            if (iREN && acc) begin
                e_iwait = 1'b0;
                e_iload = ramload;
            end
        end
    endtask

    task automatic model_advance();
        bit dreq;
        bit req;
        dreq = dREN | dWEN;
        if (m_owner == 0) begin
            m_waited = 0;
            if (FAIR_ON && m_fair == FAIR_LIMIT && iREN) begin
                m_owner = 1;
                m_fair  = 0;
            end else if (dreq) begin
                m_owner = 2;
                if (iREN) m_fair++;
            end else if (iREN) begin
                m_owner = 1;
                m_fair  = 0;
            end
        end else begin
            req = (m_owner == 2) ? dreq : iREN;
            if (!req || ramstate == ACCESS) begin
                m_owner = 0;
            end else if (ramstate == ERROR) begin
                m_err   = 1'b1;
                m_owner = 0;
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    m_err   = 1'b1;
                    m_owner = 0;
                end
            end
        end
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ramREN"},   32'(ramREN),    32'(e_ren));
        chk({tag, ".ramWEN"},   32'(ramWEN),    32'(e_wen));
        chk({tag, ".ramaddr"},  ramaddr,        e_addr);
        chk({tag, ".ramstore"}, ramstore,       e_store);
        chk({tag, ".iwait"},    32'(iwait),     32'(e_iwait));
        chk({tag, ".iload"},    iload,          e_iload);
        chk({tag, ".dwait"},    32'(dwait),     32'(e_dwait));
        chk({tag, ".dload"},    dload,          e_dload);
        chk({tag, ".err"},      32'(err),       32'(e_err));
        chk({tag, ".state"},    32'(arb_state), 32'(e_st));
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        model_reset();
    endtask

    task automatic clear_inputs();
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       iren;
        word_t      iaddr;
        logic       dren;
        logic       dwen;
        word_t      daddr;
        word_t      dstore;
        ramstate_t  rs;
        word_t      rload;
        logic       e_ren;
        logic       e_wen;
        word_t      e_addr;
        word_t      e_store;
        logic       e_iwait;
        word_t      e_iload;
        logic       e_dwait;
        word_t      e_dload;
        logic       e_err;
        arb_state_t e_st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ir, input word_t ia, input logic dr, input logic dw,
                       input word_t da, input word_t ds, input ramstate_t rs, input word_t rl,
                       input logic xr, input logic xw, input word_t xa, input word_t xs,
                       input logic xiw, input word_t xil, input logic xdw, input word_t xdl,
                       input logic xe, input arb_state_t xst);
        vec_t v;
        v.iren = ir;  v.iaddr = ia;  v.dren = dr;  v.dwen = dw;
        v.daddr = da; v.dstore = ds; v.rs = rs;    v.rload = rl;
        v.e_ren = xr; v.e_wen = xw;  v.e_addr = xa; v.e_store = xs;
        v.e_iwait = xiw; v.e_iload = xil; v.e_dwait = xdw; v.e_dload = xdl;
        v.e_err = xe; v.e_st = xst;
        vecs.push_back(v);
    endtask

    initial begin
        int ic, dc, run, max_run, r;

        // idle after reset
        add(0, 0,     0, 0, 0,     0,            FREE,   0,            0, 0, 0,     0,            1, 0,            1, 0,            0, IDLE);
        // data read at 0x40
        add(0, 0,     1, 0, 32'h40, 0,           FREE,   0,            0, 0, 0,     0,            1, 0,            1, 0,            0, IDLE);
        add(0, 0,     1, 0, 32'h40, 0,           ACCESS, 32'hDEADBEEF, 1, 0, 32'h40, 0,           1, 0,            0, 32'hDEADBEEF, 0, GRANT_D);
        add(0, 0,     0, 0, 0,     0,            FREE,   0,            0, 0, 0,     0,            1, 0,            1, 0,            0, IDLE);
        // simultaneous fetch and write: write first, then fetch
        add(1, 0,     0, 1, 32'h80, 32'h12345678, FREE,  0,            0, 0, 0,     0,            1, 0,            1, 0,            0, IDLE);
        add(1, 0,     0, 1, 32'h80, 32'h12345678, BUSY,  0,            0, 1, 32'h80, 32'h12345678, 1, 0,           1, 0,            0, GRANT_D);
        add(1, 0,     0, 1, 32'h80, 32'h12345678, ACCESS, 32'hAAAA5555, 0, 1, 32'h80, 32'h12345678, 1, 0,          0, 32'hAAAA5555, 0, GRANT_D);
        add(1, 0,     0, 0, 32'h80, 32'h12345678, FREE,  0,            0, 0, 0,     0,            1, 0,            1, 0,            0, IDLE);
        add(1, 0,     0, 0, 32'h80, 32'h12345678, ACCESS, 32'h0BADF00D, 1, 0, 0,    0,            0, 32'h0BADF00D, 1, 0,            0, GRANT_I);
        add(0, 0,     0, 0, 0,     0,            FREE,   0,            0, 0, 0,     0,            1, 0,            1, 0,            0, IDLE);
        // fetch withdrawn mid-grant: no pulse, no err
        add(1, 32'h20, 0, 0, 0,    0,            FREE,   0,            0, 0, 0,     0,            1, 0,            1, 0,            0, IDLE);
        add(1, 32'h20, 0, 0, 0,    0,            BUSY,   0,            1, 0, 32'h20, 0,           1, 0,            1, 0,            0, GRANT_I);
        add(0, 32'h20, 0, 0, 0,    0,            ACCESS, 32'h77,       0, 0, 32'h20, 0,           1, 0,            1, 0,            0, GRANT_I);
        add(0, 0,     0, 0, 0,     0,            FREE,   0,            0, 0, 0,     0,            1, 0,            1, 0,            0, IDLE);
        // ERROR during a data grant: err next cycle, request re-arbitrates
        add(0, 0,     1, 0, 32'h44, 0,           FREE,   0,            0, 0, 0,     0,            1, 0,            1, 0,            0, IDLE);
        add(0, 0,     1, 0, 32'h44, 0,           ERROR,  32'h99,       1, 0, 32'h44, 0,           1, 0,            1, 0,            0, GRANT_D);
        add(0, 0,     1, 0, 32'h44, 0,           FREE,   0,            0, 0, 0,     0,            1, 0,            1, 0,            1, IDLE);
        add(0, 0,     1, 0, 32'h44, 0,           ACCESS, 32'h11,       1, 0, 32'h44, 0,           1, 0,            0, 32'h11,       1, GRANT_D);
        add(0, 0,     0, 0, 0,     0,            FREE,   0,            0, 0, 0,     0,            1, 0,            1, 0,            1, IDLE);

        clear_inputs();
        RST = 1'b0;
        next_cycle();
        do_reset();

        foreach (vecs[i]) begin
            iREN = vecs[i].iren;  iaddr = vecs[i].iaddr;
            dREN = vecs[i].dren;  dWEN = vecs[i].dwen;
            daddr = vecs[i].daddr; dstore = vecs[i].dstore;
            ramstate = vecs[i].rs; ramload = vecs[i].rload;
            @(negedge CLK);
            e_ren = vecs[i].e_ren;     e_wen = vecs[i].e_wen;
            e_addr = vecs[i].e_addr;   e_store = vecs[i].e_store;
            e_iwait = vecs[i].e_iwait; e_iload = vecs[i].e_iload;
            e_dwait = vecs[i].e_dwait; e_dload = vecs[i].e_dload;
            e_err = vecs[i].e_err;     e_st = vecs[i].e_st;
            check_all($sformatf("vec%0d", i));
            next_cycle();
        end

        // timeout: fetch held against a BUSY RAM
        clear_inputs();
        do_reset();
        iREN = 1'b1; iaddr = 32'h100; ramstate = BUSY;
        @(negedge CLK);
        chk("tmo.idle_state", 32'(arb_state), 32'(IDLE));
        next_cycle();
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge CLK);
            chk($sformatf("tmo.grant_state%0d", k), 32'(arb_state), 32'(GRANT_I));
            chk($sformatf("tmo.iwait%0d", k), 32'(iwait), 32'(1'b1));
            chk($sformatf("tmo.err%0d", k), 32'(err), 32'(1'b0));
            next_cycle();
        end
        @(negedge CLK);
        chk("tmo.back_idle", 32'(arb_state), 32'(IDLE));
        chk("tmo.err_set", 32'(err), 32'(1'b1));
        chk("tmo.iwait_held", 32'(iwait), 32'(1'b1));
        next_cycle();
        @(negedge CLK);
        chk("tmo.regrant", 32'(arb_state), 32'(GRANT_I));
        chk("tmo.regrant_ren", 32'(ramREN), 32'(1'b1));
        next_cycle();

        // ERROR then async reset in the middle of a write grant
        clear_inputs();
        do_reset();
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'h55; ramstate = ERROR;
        @(negedge CLK);
        chk("rst.idle", 32'(arb_state), 32'(IDLE));
        next_cycle();
        @(negedge CLK);
        chk("rst.err_grant_wen", 32'(ramWEN), 32'(1'b1));
        chk("rst.err_no_pulse", 32'(dwait), 32'(1'b1));
        next_cycle();
        ramstate = BUSY;
        @(negedge CLK);
        chk("rst.err_set", 32'(err), 32'(1'b1));
        chk("rst.err_no_pulse2", 32'(dwait), 32'(1'b1));
        next_cycle();
        @(negedge CLK);
        chk("rst.pre_wen", 32'(ramWEN), 32'(1'b1));
        #2;
        RST = 1'b1;
        #1;
        chk("rst.async_wen", 32'(ramWEN), 32'(1'b0));
        chk("rst.async_addr", ramaddr, 32'h0);
        chk("rst.async_state", 32'(arb_state), 32'(IDLE));
        chk("rst.async_err", 32'(err), 32'(1'b0));
        next_cycle();
        RST = 1'b0;
        model_reset();

        // fairness: both requesters held, RAM always ready
        clear_inputs();
        do_reset();
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h4; daddr = 32'h8; ramstate = ACCESS;
        ic = 0; dc = 0; run = 0; max_run = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (!dwait) begin
                dc++;
                run++;
                if (run > max_run) max_run = run;
            end
            if (!iwait) begin
                ic++;
                run = 0;
            end
            next_cycle();
        end
`ifdef MEM_ARB_FAIR_EN
        chk("fair.icount", 32'(ic), 32'd6);
        chk("fair.dcount", 32'(dc), 32'd24);
        chk("fair.max_run", 32'(max_run), 32'(FAIR_LIMIT));
`else
        chk("nofair.icount", 32'(ic), 32'd0);
        chk("nofair.dcount", 32'(dc), 32'd30);
`endif

        // randomized run against the reference model
        clear_inputs();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 249) do_reset();
            if ($urandom_range(0, 7) == 0) begin
                iREN  = 1'($urandom_range(0, 1));
                iaddr = $urandom;
            end
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       {dREN, dWEN} = 2'b00;
                    1:       {dREN, dWEN} = 2'b10;
                    default: {dREN, dWEN} = 2'b01;
                endcase
                daddr  = $urandom;
                dstore = $urandom;
            end
            r = int'($urandom_range(0, 19));
            ramstate = (r == 0) ? ERROR : (r < 8) ? ACCESS : (r < 14) ? BUSY : FREE;
            ramload  = $urandom;
            @(negedge CLK);
            model_expect();
            check_all("rand");
            model_advance();
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
